out_port_bcd: RTL and testbench
===============================

OUT_PORT_BCD -- requirements
Module: out_port_bcd

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of buffered port writes awaiting conversion (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 write_out  input  1  port-write strobe from the Driver, one write per cycle when high.
REQ-005 out_port  input  4  target port of the write.
REQ-006 out_data  input  16  binary value written.
REQ-007 sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd  output  8 each  two packed BCD digits, tens in [7:4], ones in [3:0].
REQ-008 year_bcd  output  16  four packed BCD digits, thousands in [15:12].
REQ-009 updated  output  1  one-cycle pulse when a BCD register is committed.
REQ-010 updated_port  output  4  port number of the committed register; valid while updated is high.
REQ-011 busy  output  1  high when the converter is not IDLE or the FIFO is non-empty.
REQ-012 overflow  output  1  sticky flag: a valid write was dropped because the FIFO was full.

Function
REQ-013 A write is valid when write_out=1 and out_port<=5; writes to ports 6-15 are discarded without effect on any output, including overflow.
REQ-014 A valid write pushes {out_port, out_data} into the FIFO; ports 0-4 store out_data[7:0] zero-extended, port 5 stores all 16 bits.
REQ-015 A valid write with the FIFO full is dropped and sets overflow, unless a pop occurs on the same edge, in which case it is accepted.
REQ-016 FSM states: IDLE, SHIFT, COMMIT.
REQ-017 IDLE: on an edge with the FIFO non-empty, pop the head, load the 16-bit value into the shift register, clear the 20-bit BCD accumulator and the 4-bit iteration count, and enter SHIFT.
REQ-018 SHIFT: on each edge, add 3 to every accumulator nibble >=5, then shift {accumulator, value} left one bit and increment the count; after the 16th edge, enter COMMIT.
REQ-019 COMMIT: on the edge, write the low 8 bits (ports 0-4) or low 16 bits (port 5) of the accumulator to the target register, assert updated and updated_port for exactly the following cycle, and enter IDLE.
REQ-020 Latency: a write sampled at edge N into an empty FIFO with the FSM in IDLE is visible on its BCD output after edge N+18.
REQ-021 Throughput: one conversion per 18 cycles; a non-empty FIFO is popped on the first IDLE edge with no idle gap.
REQ-022 Values >=100 on ports 0-4 produce value mod 100; values >=10000 on port 5 produce value mod 10000.
REQ-023 FIFO order is strict: registers are committed in write order, and a later write to the same port overwrites an earlier one.
REQ-024 Outputs not being committed hold their values; no output changes outside COMMIT, except updated and updated_port deasserting.

Reset
REQ-025 When rstn=0 at a rising edge: FSM to IDLE, FIFO emptied, all BCD outputs 0x00/0x0000, updated=0, updated_port=0, busy=0, overflow=0.
REQ-026 Reset during SHIFT or COMMIT abandons the conversion; no register is written from it, and no updated pulse is produced.

Verification
REQ-027 Write port 0 value 59 at edge N -> sec_bcd=0x59 after edge N+18; updated=1 and updated_port=0 for one cycle.
REQ-028 Write port 5 value 2024 -> year_bcd=0x2024; write port 5 value 65535 -> year_bcd=0x5535.
REQ-029 Write port 1 value 0x012C (low byte 44) -> min_bcd=0x44; write port 2 value 123 -> hour_bcd=0x23.
REQ-030 Six back-to-back valid writes (ports 0-5, values 1-6) starting in IDLE -> first five committed in order, 18 cycles apart, sixth dropped, overflow=1, year_bcd remains 0x0000.
REQ-031 Write port 7 value 99 -> no output change, busy stays 0, overflow stays 0.
REQ-032 Write port 3 value 31, then assert rstn=0 at edge N+10 -> day_bcd=0x00, no updated pulse, busy=0; a subsequent write of 12 to port 4 -> month_bcd=0x12 after 18 cycles.

Source files
------------

// File: rtl/out_port_bcd_if.sv
// -----------------------------------------------------------------------------
// out_port_bcd_if
// Port-write bus from the Driver into the BCD output-port block.
//   write_out : write strobe, one write per cycle while high
//   out_port  : target port number (0-5 meaningful, 6-15 ignored by the slave)
//   out_data  : binary value written
// Modports: master (Driver side, drives the bus), slave (out_port_bcd side).
// -----------------------------------------------------------------------------
interface out_port_bcd_if;
    logic        write_out;
    logic [3:0]  out_port;
    logic [15:0] out_data;

    modport master (output write_out, output out_port, output out_data);
    modport slave  (input  write_out, input  out_port, input  out_data);
endinterface

// File: rtl/out_port_bcd.sv
// -----------------------------------------------------------------------------
// out_port_bcd
// Buffers binary port writes in a small FIFO and converts them one at a time
// into packed BCD with a serial double-dabble converter (18 cycles per value).
//   clk          : single clock, rising edge
//   rstn         : synchronous active-low reset
//   bus          : write bus (write_out, out_port, out_data), slave side
//   sec_bcd .. month_bcd : ports 0-4, two BCD digits (value mod 100)
//   year_bcd     : port 5, four BCD digits (value mod 10000)
//   updated      : one-cycle pulse when a register is committed
//   updated_port : port number of that commit, valid while updated is high
//   busy         : converter active or FIFO holding pending writes
//   overflow     : sticky, a valid write was dropped on a full FIFO
// -----------------------------------------------------------------------------
module out_port_bcd #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    out_port_bcd_if.slave    bus,
    output logic [7:0]       sec_bcd,
    output logic [7:0]       min_bcd,
    output logic [7:0]       hour_bcd,
    output logic [7:0]       day_bcd,
    output logic [7:0]       month_bcd,
    output logic [15:0]      year_bcd,
    output logic             updated,
    output logic [3:0]       updated_port,
    output logic             busy,
    output logic             overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0]  port;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // ---------------------------------------------------------------- FIFO
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    entry_t             head;
    logic               wr_valid, fifo_full, fifo_empty, push, pop;

    state_t             state;
    logic [15:0]        value;
    logic [19:0]        acc;
    logic [19:0]        acc_adj;
    logic [3:0]         iter;
    logic [3:0]         tgt_port;

    assign wr_valid   = bus.write_out && (bus.out_port <= 4'd5);
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = (state == IDLE) && !fifo_empty;
    // A full FIFO still accepts a write on the edge that frees a slot.
    assign push       = wr_valid && (!fifo_full || pop);
    assign head       = mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;

    // NOTE: storage has no reset; only the pointers and count define which
    // entries are live, so clearing the array would just cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            // Ports 0-4 only carry a byte; port 5 keeps the full word.
            mem[wr_ptr] <= '{port: bus.out_port,
                             data: (bus.out_port == 4'd5) ? bus.out_data
                                                          : {8'h00, bus.out_data[7:0]}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_valid && !push) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------ double dabble
    // NOTE: every combinational output gets a default before any condition so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            value        <= '0;
            acc          <= '0;
            iter         <= '0;
            tgt_port     <= '0;
            sec_bcd      <= '0;
            min_bcd      <= '0;
            hour_bcd     <= '0;
            day_bcd      <= '0;
            month_bcd    <= '0;
            year_bcd     <= '0;
            updated      <= 1'b0;
            updated_port <= '0;
        end else begin
            updated      <= 1'b0;
            updated_port <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        value    <= head.data;
                        tgt_port <= head.port;
                        acc      <= '0;
                        iter     <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[18:0], value[15]};
                    value <= {value[14:0], 1'b0};
                    iter  <= iter + 4'd1;
                    if (iter == 4'd15) state <= COMMIT;
                end
                COMMIT: begin
                    // Truncating the BCD result gives value mod 100 / mod 10000.
                    case (tgt_port)
                        4'd0:    sec_bcd   <= acc[7:0];
                        4'd1:    min_bcd   <= acc[7:0];
                        4'd2:    hour_bcd  <= acc[7:0];
                        4'd3:    day_bcd   <= acc[7:0];
                        4'd4:    month_bcd <= acc[7:0];
                        4'd5:    year_bcd  <= acc[15:0];
                        default: ;
                    endcase
                    updated      <= 1'b1;
                    updated_port <= tgt_port;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_bcd.sv
// -----------------------------------------------------------------------------
// tb_out_port_bcd
// Directed and randomized stimulus for out_port_bcd, compared every cycle
// against a transaction-level reference: a queue of pending writes, a
// countdown for the conversion in flight, and decimal arithmetic for BCD.
// -----------------------------------------------------------------------------
module tb_out_port_bcd;

    localparam int DEPTH = 4;
    localparam int CONV_EDGES = 17;  // edges from pop to commit

    logic        clk;
    logic        rstn;
    logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd;
    logic [15:0] year_bcd;
    logic        updated;
    logic [3:0]  updated_port;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    out_port_bcd_if bus ();

    out_port_bcd #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .sec_bcd      (sec_bcd),
        .min_bcd      (min_bcd),
        .hour_bcd     (hour_bcd),
        .day_bcd      (day_bcd),
        .month_bcd    (month_bcd),
        .year_bcd     (year_bcd),
        .updated      (updated),
        .updated_port (updated_port),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    typedef struct {
        int port;
        int value;
    } wr_t;

    wr_t  m_q[$];
    wr_t  m_cur;
    int   m_timer = 0;
    int   m_regs[6] = '{default: 0};
    bit   m_updated = 0;
    int   m_upd_port = 0;
    bit   m_overflow = 0;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    always @(posedge clk) begin
        int  sz;
        bit  popped;
        wr_t w;
        if (!rstn) begin
            m_q.delete();
            m_timer    = 0;
            m_regs     = '{default: 0};
            m_updated  = 0;
            m_upd_port = 0;
            m_overflow = 0;
        end else begin
            m_updated = 0;
            popped    = 0;
            sz        = m_q.size();
            if (m_timer == 0) begin
                if (sz > 0) begin
                    m_cur   = m_q.pop_front();
                    m_timer = CONV_EDGES;
                    popped  = 1;
                end
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_regs[m_cur.port] = (m_cur.port == 5) ? to_bcd(m_cur.value % 10000)
                                                           : to_bcd(m_cur.value % 100);
                    m_updated  = 1;
                    m_upd_port = m_cur.port;
                end
            end
            if (bus.write_out && bus.out_port <= 4'd5) begin
                w.port  = int'(bus.out_port);
                w.value = (bus.out_port == 4'd5) ? int'(bus.out_data) : int'(bus.out_data[7:0]);
                if (sz < DEPTH || popped) m_q.push_back(w);
                else m_overflow = 1;
            end
        end
    end

    // -------------------------------------------------------------- checking
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("sec",      {8'h00, sec_bcd},   16'(m_regs[0]));
        chk("min",      {8'h00, min_bcd},   16'(m_regs[1]));
        chk("hour",     {8'h00, hour_bcd},  16'(m_regs[2]));
        chk("day",      {8'h00, day_bcd},   16'(m_regs[3]));
        chk("month",    {8'h00, month_bcd}, 16'(m_regs[4]));
        chk("year",     year_bcd,           16'(m_regs[5]));
        chk("updated",  {15'h0, updated},   {15'h0, m_updated});
        chk("busy",     {15'h0, busy},      {15'h0, (m_timer != 0 || m_q.size() != 0)});
        chk("overflow", {15'h0, overflow},  {15'h0, m_overflow});
        if (m_updated) chk("updated_port", {12'h0, updated_port}, 16'(m_upd_port));
    endtask

    // One clock: drive inputs on the falling edge, sample #1 after the rising edge.
    task automatic cycle(input logic we, input logic [3:0] p, input logic [15:0] d, input logic rn);
        @(negedge clk);
        bus.write_out = we;
        bus.out_port  = p;
        bus.out_data  = d;
        rstn          = rn;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 16'h0000, 1'b1);
    endtask

    task automatic wr(input logic [3:0] p, input logic [15:0] d);
        cycle(1'b1, p, d, 1'b1);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        bus.write_out = 1'b0;
        bus.out_port  = 4'd0;
        bus.out_data  = 16'h0000;
        rstn          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, 4'd0, 16'h0000, 1'b0);
        chk("rst_sec",      {8'h00, sec_bcd}, 16'h0000);
        chk("rst_year",     year_bcd, 16'h0000);
        chk("rst_busy",     {15'h0, busy}, 16'h0000);
        chk("rst_overflow", {15'h0, overflow}, 16'h0000);
        chk("rst_updated",  {15'h0, updated}, 16'h0000);

        // Port 0 value 59: visible after edge N+18, pulse for one cycle.
        wr(4'd0, 16'd59);
        idle(17);
        chk("sec59_early", {8'h00, sec_bcd}, 16'h0000);
        idle(1);
        chk("sec59",       {8'h00, sec_bcd}, 16'h0059);
        chk("sec59_upd",   {15'h0, updated}, 16'h0001);
        chk("sec59_port",  {12'h0, updated_port}, 16'h0000);
        idle(1);
        chk("sec59_pulse", {15'h0, updated}, 16'h0000);

        // Year values, including mod 10000 wrap.
        wr(4'd5, 16'd2024);
        idle(18);
        chk("year2024", year_bcd, 16'h2024);
        wr(4'd5, 16'd65535);
        idle(18);
        chk("year65535", year_bcd, 16'h5535);

        // Byte truncation and mod 100.
        wr(4'd1, 16'h012C);
        idle(18);
        chk("min44", {8'h00, min_bcd}, 16'h0044);
        wr(4'd2, 16'd123);
        idle(18);
        chk("hour23", {8'h00, hour_bcd}, 16'h0023);

        // Six back-to-back writes into a fresh block: sixth is dropped.
        cycle(1'b0, 4'd0, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) wr(4'(i), 16'(i + 1));
        idle(5 * 18);
        chk("burst_sec",      {8'h00, sec_bcd},   16'h0001);
        chk("burst_month",    {8'h00, month_bcd}, 16'h0005);
        chk("burst_year",     year_bcd,           16'h0000);
        chk("burst_overflow", {15'h0, overflow},  16'h0001);
        chk("burst_busy",     {15'h0, busy},      16'h0000);

        // Writes to ports 6-15 are ignored entirely.
        cycle(1'b0, 4'd0, 16'h0000, 1'b0);
        wr(4'd7, 16'd99);
        chk("p7_busy", {15'h0, busy}, 16'h0000);
        idle(20);
        chk("p7_overflow", {15'h0, overflow}, 16'h0000);
        chk("p7_sec",      {8'h00, sec_bcd},  16'h0000);

        // Reset mid-conversion abandons it.
        wr(4'd3, 16'd31);
        idle(9);
        cycle(1'b0, 4'd0, 16'h0000, 1'b0);
        chk("abort_day",  {8'h00, day_bcd}, 16'h0000);
        chk("abort_busy", {15'h0, busy},    16'h0000);
        idle(20);
        chk("abort_day_later", {8'h00, day_bcd}, 16'h0000);
        wr(4'd4, 16'd12);
        idle(18);
        chk("month12", {8'h00, month_bcd}, 16'h0012);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 249) != 0));
        end
        idle(6 * 18);
        chk("drain_busy", {15'h0, busy}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
